// File: rtl/seg_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan controller.
// Segment order is {a,b,c,d,e,f,g,dp}; all outputs are active-low.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic {
    BLANK,
    DRIVE
  } seg_state_e;

  localparam logic [7:0] SEG_HEX [16] = '{
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
    8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
    8'b00000001, 8'b00011001, 8'b00010001, 8'b11000001,
    8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
// The dp segment is driven from the separate dp flag.
import seg_pkg::*;

module seg_hex_decode (
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  // table lookup, then overlay the decimal point
  always_comb begin
    seg    = SEG_HEX[nib];
    seg[0] = ~dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit multiplexed display scheduler with blank gaps and frame-synced updates.
// Optional macro SEG_SCAN_BRIGHT_EN adds a bright[2:0] duty-cycle input.
import seg_pkg::*;

module seg_scan_ctrl #(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        blank_lz,
`ifdef SEG_SCAN_BRIGHT_EN
  input  logic [2:0]  bright,
`endif
  output logic        wr_ready,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);

  seg_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [15:0] act_q, act_d;
  logic [3:0]  act_dp_q, act_dp_d;
  logic [15:0] sh_q, sh_d;
  logic [3:0]  sh_dp_q, sh_dp_d;
  logic        sh_full_q, sh_full_d;
  logic        lz_q, lz_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        fs_q, fs_d;

  logic        slot_end, frame_end, wr_ok;
  logic [3:0]  nib;
  logic        dp_bit, lz_blank, an_on;
  logic [7:0]  dec_seg;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (digit_q == 2'd3);
  assign wr_ok     = wr_en && !sh_full_q;
  assign nib       = act_q[{digit_q, 2'b00} +: 4];
  assign dp_bit    = act_dp_q[digit_q];

  seg_hex_decode u_dec (
    .nib (nib),
    .dp  (dp_bit),
    .seg (dec_seg)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BLANK;
    else       state_q <= state_d;
  end

  // FSM next state: blank gap first, then drive until slot end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BLANK: if (cnt_q == BLK_LAST) state_d = DRIVE;
      DRIVE: if (slot_end)          state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // leading-zero test: this nibble and all higher ones are zero
  always_comb begin
    lz_blank = 1'b0;
    unique case (digit_q)
      2'd3: lz_blank = lz_q && (act_q[15:12] == 4'h0);
      2'd2: lz_blank = lz_q && (act_q[15:8] == 8'h00);
      2'd1: lz_blank = lz_q && (act_q[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  end

  // anode-on window inside DRIVE (full window unless dimmed)
`ifdef SEG_SCAN_BRIGHT_EN
  always_comb begin
    int on_len;
    on_len = ((SLOT_CYC - BLANK_CYC) * (int'(bright) + 1)) / 8;
    if (on_len < 1) on_len = 1;
    an_on = (int'(cnt_q) - BLANK_CYC) < on_len;
  end
`else
  assign an_on = 1'b1;
`endif

  // FSM outputs: pin values for the next cycle
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (state_q == DRIVE && an_on) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = lz_blank ? {7'h7F, ~dp_bit} : dec_seg;
    end
  end

  // slot counter, digit rotation, shadow handshake, frame swap
  always_comb begin
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    digit_d   = slot_end ? digit_q + 2'd1 : digit_q;
    lz_d      = (cnt_q == '0) ? blank_lz : lz_q;
    fs_d      = frame_end;
    act_d     = act_q;
    act_dp_d  = act_dp_q;
    sh_d      = sh_q;
    sh_dp_d   = sh_dp_q;
    sh_full_d = sh_full_q;
    if (frame_end && sh_full_q) begin
      act_d     = sh_q;
      act_dp_d  = sh_dp_q;
      sh_full_d = 1'b0;
    end
    if (wr_ok) begin
      sh_d      = wr_data;
      sh_dp_d   = wr_dp;
      sh_full_d = 1'b1;
    end
  end

  // datapath and registered pin flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      digit_q   <= 2'd0;
      lz_q      <= 1'b0;
      fs_q      <= 1'b0;
      act_q     <= 16'h0000;
      act_dp_q  <= 4'h0;
      sh_q      <= 16'h0000;
      sh_dp_q   <= 4'h0;
      sh_full_q <= 1'b0;
      seg_q     <= SEG_OFF;
      an_q      <= AN_OFF;
    end else begin
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      lz_q      <= lz_d;
      fs_q      <= fs_d;
      act_q     <= act_d;
      act_dp_q  <= act_dp_d;
      sh_q      <= sh_d;
      sh_dp_q   <= sh_dp_d;
      sh_full_q <= sh_full_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;
  assign wr_ready    = ~sh_full_q;

endmodule
